des_perm_pipe: RTL
==================

# des_perm_pipe

Parametrised DES bit-permutation pipeline that applies the initial permutation (IP), the final permutation (IP⁻¹/FP) or bypass to LANES independent 64-bit blocks per beat. It carries a per-beat mode and valid/ready backpressure through STAGES register stages. It serves as the common entry/exit permutation unit for the DES datapath: IP on plaintext before round 1, FP on the R16L16 combination after round 16.

## Interface
- LANES, 1, number of 64-bit blocks per beat (1..8)
- STAGES, 1, pipeline register stages (1..4); latency in cycles
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  unit accepts beat this cycle
- in_mode  in  2  00 bypass, 01 IP, 10 FP, 11 reserved
- in_data  in  64*LANES  lane k = bits [64k+63:64k]; DES bit 1 = lane MSB
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- out_data  out  64*LANES  permuted lanes
- out_err  out  1  beat entered with in_mode = 11
- busy  out  1  any stage holds a valid beat

## Operation
- Clock is `clk` and reset is `rst`: one clock, synchronous active-high reset.
- Per lane, output DES bit i = input DES bit T[i], with i = 1..64.
- IP table T starts 58,50,42,34,26,18,10,2,60,52,… and ends …,63,55,47,39,31,23,15,7.
- FP table T starts 40,8,48,16,56,24,64,32,39,7,… and ends …,33,1,41,9,49,17,57,25.
- Bypass is the identity. All lanes in a beat use the same mode.
- Mode 11 passes data as bypass and sets out_err for that beat only.
- Permutation is combinational before stage 1; stages 2..STAGES are pure delay with the same handshake.
- Stage s holds valid_s, data_s and err_s.
- Stage s loads when it is empty, or when it is advancing (its contents move to s+1 or out) in the same cycle.
- in_ready = stage 1 can load. out_valid = valid of last stage.
- A transfer occurs on valid && ready at each boundary. No beat is dropped or duplicated.
- busy = OR of all valid_s.

## Timing
- Reset (rst=1 at a clk edge): all valid_s = 0, data_s = 0, err_s = 0.
- So out_valid = 0, out_data = 0, out_err = 0 and busy = 0. in_ready = 1 from the first cycle after reset.
- Reset mid-stream discards every in-flight beat, with no partial output.
- Latency: a beat accepted at edge n appears on out_valid after edge n+STAGES-1, and is available at edge n+STAGES if out_ready=1.
- Throughput: 1 beat/cycle with out_ready held high.
- Full: when all STAGES hold beats and out_ready=0, in_ready=0 in that same cycle.
- in_ready depends combinationally on out_ready. This is a bubble-free ready chain; no skid buffer.
- Simultaneous accept and drain when full: an output transfer and an input transfer happen on the same edge, and occupancy is unchanged.
- out_data, out_err and out_valid are held stable while out_valid=1 and out_ready=0.
- in_data and in_mode are ignored when in_valid=0. Stage contents do not change when the stage is not loading.

## Structure
- Package des_perm_pkg holds:
  - IP_TABLE and FP_TABLE as 64-entry constant arrays of 7-bit indices (1-based DES numbering);
  - mode constants MODE_BYPASS=2'b00, MODE_IP=2'b01, MODE_FP=2'b10, MODE_RSVD=2'b11;
  - function des_bit(idx) mapping DES bit number to vector index 64-idx.
- Sub-module des_perm_lane: a combinational 64-bit permute of (data, mode), instantiated LANES times by generate.
- Top module: stage registers and handshake only.

## Test plan
- LANES=1, STAGES=1:
  - IP on 0x0123456789ABCDEF -> 0xCC00CCFFF0AAF0AA, out_err=0, one cycle later.
  - FP on 0xCC00CCFFF0AAF0AA -> 0x0123456789ABCDEF.
- LANES=2, STAGES=3, out_ready=1, modes IP/FP/bypass/11 back-to-back over 4 cycles:
  - outputs appear on 4 consecutive cycles starting 3 cycles after the first accept;
  - lane data is correct per lane; out_err=1 only on the 4th beat.
- STAGES=3, out_ready=0, in_valid=1 continuously:
  - exactly 3 beats accepted, then in_ready=0 and busy=1;
  - raising out_ready for 1 cycle drains one beat and accepts one beat the same edge.
- Random in_valid/out_ready (50% each), 10k beats:
  - scoreboard matches a software IP/FP model;
  - order preserved; no drop or duplicate;
  - out_data stable while stalled.
- rst asserted for one cycle with 2 beats in flight:
  - next cycle out_valid=0, out_data=0, busy=0, in_ready=1;
  - neither pre-reset beat ever appears.
- FP(IP(x)) round trip through two chained instances for 1000 random 64-bit x -> output equals x.

Source files
------------

// File: rtl/des_perm_pkg.sv
// des_perm_pkg: DES IP/FP tables, mode codes and bit-numbering helper.
package des_perm_pkg;
  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_IP = 2'b01;
  localparam logic [1:0] MODE_FP = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;
  localparam logic [6:0] IP_TABLE [64] = '{
    7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
    7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
    7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
    7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9, 7'd1,
    7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
    7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
  };
  localparam logic [6:0] FP_TABLE [64] = '{
    7'd40, 7'd8, 7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
    7'd39, 7'd7, 7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
    7'd38, 7'd6, 7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
    7'd37, 7'd5, 7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
    7'd36, 7'd4, 7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
    7'd35, 7'd3, 7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
    7'd34, 7'd2, 7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
    7'd33, 7'd1, 7'd41, 7'd9, 7'd49, 7'd17, 7'd57, 7'd25
  };
  // DES numbers bits 1..64 from the MSB down
  function automatic int des_bit(input int idx);
    return 64 - idx;
  endfunction
endpackage

// File: rtl/des_perm_lane.sv
// des_perm_lane: combinational IP/FP/bypass permutation of one 64-bit block.
module des_perm_lane
  import des_perm_pkg::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  mode,
  output logic [63:0] out
);
  logic [63:0] ip, fp;
  always_comb begin
    ip = '0;
    fp = '0;
    for (int i = 1; i <= 64; i++) begin
      ip[des_bit(i)] = data[des_bit(int'(IP_TABLE[i-1]))];
      fp[des_bit(i)] = data[des_bit(int'(FP_TABLE[i-1]))];
    end
    out = mode == MODE_IP ? ip : mode == MODE_FP ? fp : data;
  end
endmodule

// File: rtl/des_perm_pipe.sv
// des_perm_pipe: LANES-wide DES permutation followed by a STAGES-deep valid/ready pipeline.
module des_perm_pipe
  import des_perm_pkg::*;
#(
  parameter int LANES = 1,
  parameter int STAGES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_mode,
  input  logic [64*LANES-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [64*LANES-1:0]   out_data,
  output logic                  out_err,
  output logic                  busy
);
  logic [64*LANES-1:0] perm;
  logic [64*LANES-1:0] dat [STAGES];
  logic [64*LANES-1:0] pd [STAGES+1];
  logic [STAGES-1:0] vld, err, load;
  logic [STAGES:0] pv, pe;
  logic full;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    des_perm_lane u_lane (.data(in_data[64*l +: 64]), .mode(in_mode), .out(perm[64*l +: 64]));
  end
  assign pv = {vld, in_valid};
  assign pe = {err, in_mode == MODE_RSVD};
  // a stage can load if out_ready is high or any stage at or after it is empty
  always_comb begin
    load = '0;
    full = 1'b1;
    pd[0] = perm;
    for (int s = STAGES - 1; s >= 0; s--) begin
      full = full & vld[s];
      load[s] = out_ready | ~full;
    end
    for (int s = 0; s < STAGES; s++) pd[s+1] = dat[s];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      err <= '0;
      for (int s = 0; s < STAGES; s++) dat[s] <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (load[s]) begin
          vld[s] <= pv[s];
          err[s] <= pv[s] & pe[s];
          if (pv[s]) dat[s] <= pd[s];
        end
      end
    end
  end
  assign in_ready = load[0];
  assign out_valid = vld[STAGES-1];
  assign out_data = dat[STAGES-1];
  assign out_err = err[STAGES-1];
  assign busy = |vld;
endmodule
